// File: rtl/cfi_violation_tracker_pkg.sv
// Shared types for the CFI violation tracker: exception bundle,
// commit entry, log entry and FSM state.
package cfi_violation_tracker_pkg;

  localparam int unsigned VLEN = 64;
  localparam int unsigned XLEN = 64;

  localparam logic [XLEN-1:0] BREAKPOINT = 64'd3;
  localparam logic [XLEN-1:0] CFI_CAUSE  = BREAKPOINT;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
  } scoreboard_entry_t;

  typedef struct packed {
    logic [VLEN-1:0] pc;
  } cfi_log_entry_t;

  typedef enum logic [0:0] {
    IDLE,
    PENDING
  } cfi_state_e;

endpackage

// File: rtl/cfi_violation_tracker_if.sv
// Bundle between the tracker and its commit/CSR neighbours.
// The master side drives the _i signals, the tracker is the slave.
interface cfi_violation_tracker_if
  import cfi_violation_tracker_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned CNT_W           = 16
) ();

  logic                                csr_en_i;
  logic [NR_COMMIT_PORTS-1:0]          commit_ack_i;
  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i;
  exception_t                          parser_ex_i;
  exception_t                          ex_o;
  logic                                ex_ack_i;
  logic [CNT_W-1:0]                    cnt_o;
  logic                                log_valid_o;
  logic [VLEN-1:0]                     log_pc_o;
  logic                                log_pop_i;
  logic                                log_overflow_o;
  logic                                log_clr_i;

  modport master (
    output csr_en_i, commit_ack_i, commit_instr_i,
    output parser_ex_i, ex_ack_i, log_pop_i, log_clr_i,
    input  ex_o, cnt_o, log_valid_o, log_pc_o,
    input  log_overflow_o
  );

  modport slave (
    input  csr_en_i, commit_ack_i, commit_instr_i,
    input  parser_ex_i, ex_ack_i, log_pop_i, log_clr_i,
    output ex_o, cnt_o, log_valid_o, log_pc_o,
    output log_overflow_o
  );

endinterface

// File: rtl/cfi_violation_tracker_log_fifo.sv
// Small circular log of violation entries with a sticky overflow
// flag; clear beats push/pop, a pop frees room for a same-cycle push.
module cfi_log_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             ovf_q;
  logic             empty, full;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push_i & full & ~do_pop) ovf_q <= 1'b1;
    end
  end

  assign data_o     = empty ? '0 : mem_q[rptr_q];
  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/cfi_violation_tracker.sv
// Binds parser violation pulses to the committing PC, holds the
// exception until acked, and keeps a counter plus a PC log.
module cfi_violation_tracker
  import cfi_violation_tracker_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned LOG_DEPTH       = 4,
  parameter int unsigned CNT_W           = 16
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  cfi_violation_tracker_if.slave trk
);

  localparam int unsigned LW = $clog2(LOG_DEPTH);

  cfi_state_e      state_q;
  exception_t      ex_q, ex_new;
  logic [VLEN-1:0] cap_pc_q, cap_pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic            acc;
  logic [LW:0]     log_cnt;
  cfi_log_entry_t  push_e, head_e;

  assign acc = trk.parser_ex_i.valid & trk.csr_en_i;

  // Highest-index acked port is the youngest committed instruction.
  always_comb begin
    cap_pc_d = cap_pc_q;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (trk.commit_ack_i[i]) cap_pc_d = trk.commit_instr_i[i].pc;
    end
  end

  always_comb begin
    ex_new       = '0;
    ex_new.valid = 1'b1;
    ex_new.cause = trk.parser_ex_i.cause;
    ex_new.tval  = XLEN'(cap_pc_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ex_q     <= '0;
      cap_pc_q <= '0;
    end else begin
      cap_pc_q <= cap_pc_d;
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            state_q <= PENDING;
            ex_q    <= ex_new;
          end
        end
        PENDING: begin
          if (trk.ex_ack_i) begin
            state_q <= acc ? PENDING : IDLE;
            ex_q    <= acc ? ex_new : '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (trk.log_clr_i) begin
      cnt_q <= '0;
    end else if (acc && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign push_e.pc = cap_pc_q;

  cfi_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH ($bits(cfi_log_entry_t))
  ) i_log (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (acc),
    .pop_i      (trk.log_pop_i),
    .clr_i      (trk.log_clr_i),
    .data_i     (push_e),
    .data_o     (head_e),
    .count_o    (log_cnt),
    .overflow_o (trk.log_overflow_o)
  );

  assign trk.ex_o        = ex_q;
  assign trk.cnt_o       = cnt_q;
  assign trk.log_valid_o = (log_cnt != '0);
  assign trk.log_pc_o    = head_e.pc;

endmodule

// File: tb/tb_cfi_violation_tracker.sv
// Bench for cfi_violation_tracker: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_cfi_violation_tracker;
  import cfi_violation_tracker_pkg::*;

  localparam int NP = 2;
  localparam int LD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cfi_violation_tracker_if #(.NR_COMMIT_PORTS(NP), .CNT_W(16)) ifa ();
  cfi_violation_tracker_if #(.NR_COMMIT_PORTS(NP), .CNT_W(2))  ifb ();

  assign ifb.csr_en_i       = ifa.csr_en_i;
  assign ifb.commit_ack_i   = ifa.commit_ack_i;
  assign ifb.commit_instr_i = ifa.commit_instr_i;
  assign ifb.parser_ex_i    = ifa.parser_ex_i;
  assign ifb.ex_ack_i       = ifa.ex_ack_i;
  assign ifb.log_pop_i      = ifa.log_pop_i;
  assign ifb.log_clr_i      = ifa.log_clr_i;

  cfi_violation_tracker #(.NR_COMMIT_PORTS(NP), .LOG_DEPTH(LD), .CNT_W(16)) dut_a (
    .clk_i (clk), .rst_ni (rst_n), .trk (ifa.slave)
  );
  cfi_violation_tracker #(.NR_COMMIT_PORTS(NP), .LOG_DEPTH(LD), .CNT_W(2)) dut_b (
    .clk_i (clk), .rst_ni (rst_n), .trk (ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_pend;
  logic [63:0] m_cause, m_tval, m_cap;
  int          m_cnt_a, m_cnt_b;
  logic [63:0] m_log[$];
  bit          m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_cause = '0; m_tval = '0; m_cap = '0;
    m_cnt_a = 0; m_cnt_b = 0; m_log.delete(); m_ovf = 0;
  endtask

  task automatic drive(input logic [1:0] ack, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic pv, input logic [63:0] cause, input logic en,
                       input logic exack, input logic pop, input logic clr);
    ifa.commit_ack_i          = ack;
    ifa.commit_instr_i[0].pc  = pc0;
    ifa.commit_instr_i[1].pc  = pc1;
    ifa.parser_ex_i.valid     = pv;
    ifa.parser_ex_i.cause     = cause;
    ifa.parser_ex_i.tval      = {$urandom, $urandom};
    ifa.csr_en_i              = en;
    ifa.ex_ack_i              = exack;
    ifa.log_pop_i             = pop;
    ifa.log_clr_i             = clr;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ex_valid"}, 64'(ifa.ex_o.valid), 64'(m_pend));
    if (m_pend) begin
      chk({tag, ".ex_cause"}, ifa.ex_o.cause, m_cause);
      chk({tag, ".ex_tval"},  ifa.ex_o.tval,  m_tval);
    end
    chk({tag, ".cnt16"},     64'(ifa.cnt_o), 64'(m_cnt_a));
    chk({tag, ".cnt2"},      64'(ifb.cnt_o), 64'(m_cnt_b));
    chk({tag, ".log_valid"}, 64'(ifa.log_valid_o), 64'(m_log.size() > 0));
    chk({tag, ".log_pc"},    ifa.log_pc_o, (m_log.size() > 0) ? m_log[0] : 64'h0);
    chk({tag, ".overflow"},  64'(ifa.log_overflow_o), 64'(m_ovf));
  endtask

  // Advance one clock: update the model from the applied inputs, then
  // compare the DUT one time unit after the edge.
  task automatic tick(input string tag);
    bit acc;
    logic [63:0] ncap;
    acc  = ifa.parser_ex_i.valid && ifa.csr_en_i;
    ncap = m_cap;
    for (int i = NP - 1; i >= 0; i--) begin
      if (ifa.commit_ack_i[i]) begin
        ncap = ifa.commit_instr_i[i].pc;
        break;
      end
    end
    if (!m_pend) begin
      if (acc) begin
        m_pend = 1; m_cause = ifa.parser_ex_i.cause; m_tval = m_cap;
      end
    end else if (ifa.ex_ack_i) begin
      if (acc) begin
        m_cause = ifa.parser_ex_i.cause; m_tval = m_cap;
      end else begin
        m_pend = 0;
      end
    end
    if (ifa.log_clr_i) begin
      m_cnt_a = 0; m_cnt_b = 0; m_log.delete(); m_ovf = 0;
    end else begin
      if (acc && m_cnt_a < 65535) m_cnt_a++;
      if (acc && m_cnt_b < 3) m_cnt_b++;
      if (ifa.log_pop_i && m_log.size() > 0) void'(m_log.pop_front());
      if (acc) begin
        if (m_log.size() < LD) m_log.push_back(m_cap);
        else m_ovf = 1;
      end
    end
    m_cap = ncap;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [1:0]  ack;
    logic [63:0] pc0, pc1;
    logic        pv, en, exack, pop;
    logic        exv;
    logic [63:0] tval;
    logic [15:0] cnt;
    logic        logv;
    logic [63:0] logpc;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] ack, input logic [63:0] pc0, input logic [63:0] pc1,
                              input logic pv, input logic en, input logic exack, input logic pop,
                              input logic exv, input logic [63:0] tval, input logic [15:0] cnt,
                              input logic logv, input logic [63:0] logpc);
    vec_t v;
    v.ack = ack; v.pc0 = pc0; v.pc1 = pc1; v.pv = pv; v.en = en; v.exack = exack;
    v.pop = pop; v.exv = exv; v.tval = tval; v.cnt = cnt; v.logv = logv; v.logpc = logpc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    localparam logic [63:0] P0 = 64'h8000_0010;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    tbl.push_back(mk(2'b10, 64'h0, P0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 1, 0, 0, 1, P0, 1, 1, P0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 0, 1, P0, 1, 1, P0));
    tbl.push_back(mk(2'b01, 64'h20, 0, 0, 1, 0, 0, 1, P0, 1, 1, P0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 1, 0, 0, 1, P0, 2, 1, P0));
    tbl.push_back(mk(2'b11, 64'h99, 64'h30, 0, 1, 0, 0, 1, P0, 2, 1, P0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 1, 1, 0, 1, 64'h30, 3, 1, P0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 3, 1, P0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1, 64'h20));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 3, 1, 64'h30));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 3, 0, 64'h0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 3, 0, 64'h0));
    tbl.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 64'h0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.ex_cause", ifa.ex_o.cause, 64'h0);
    chk("reset.ex_tval",  ifa.ex_o.tval,  64'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ack, tbl[i].pc0, tbl[i].pc1, tbl[i].pv, CFI_CAUSE, tbl[i].en,
            tbl[i].exack, tbl[i].pop, 1'b0);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exv", i), 64'(ifa.ex_o.valid), 64'(tbl[i].exv));
      if (tbl[i].exv) begin
        chk($sformatf("vec%0d.tval", i), ifa.ex_o.tval, tbl[i].tval);
        chk($sformatf("vec%0d.cause", i), ifa.ex_o.cause, CFI_CAUSE);
      end
      chk($sformatf("vec%0d.cnt", i), 64'(ifa.cnt_o), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d.logv", i), 64'(ifa.log_valid_o), 64'(tbl[i].logv));
      chk($sformatf("vec%0d.logpc", i), ifa.log_pc_o, tbl[i].logpc);
    end

    // overflow after five violations, saturation of the 2-bit counter
    drive(2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    tick("clr0");
    for (int k = 0; k < 5; k++) begin
      drive(2'b01, 64'h1000 + 64'(16 * k), 0, k > 0, CFI_CAUSE, 1, 1, 0, 0);
      tick($sformatf("ovf_push%0d", k));
    end
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 1, 0, 0);
    tick("ovf_push5");
    chk("ovf.flag",  64'(ifa.log_overflow_o), 64'h1);
    chk("ovf.cnt16", 64'(ifa.cnt_o), 64'd5);
    chk("ovf.cnt2",  64'(ifb.cnt_o), 64'd3);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf.order%0d", k), ifa.log_pc_o, 64'h1000 + 64'(16 * k));
      drive(2'b00, 0, 0, 0, 0, 1, 1, 1, 0);
      tick($sformatf("ovf_pop%0d", k));
    end
    chk("ovf.drained", 64'(ifa.log_valid_o), 64'h0);

    // push+pop while full must not overflow
    drive(2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    tick("clr1");
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 64'h2000 + 64'(8 * k), 0, k > 0, CFI_CAUSE, 1, 1, 0, 0);
      tick($sformatf("full_push%0d", k));
    end
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 1, 0, 0);
    tick("full_push4");
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 1, 1, 0);
    tick("full_pushpop");
    chk("full.pushpop_noovf", 64'(ifa.log_overflow_o), 64'h0);
    chk("full.pushpop_head",  ifa.log_pc_o, 64'h2008);
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 1, 0, 0);
    tick("full_drop");
    chk("full.drop_ovf", 64'(ifa.log_overflow_o), 64'h1);

    // clear wins over a simultaneous accept
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 0, 0, 1);
    tick("clr_acc");
    chk("clr_acc.cnt",  64'(ifa.cnt_o), 64'h0);
    chk("clr_acc.logv", 64'(ifa.log_valid_o), 64'h0);
    chk("clr_acc.ovf",  64'(ifa.log_overflow_o), 64'h0);

    // asynchronous reset while an exception is pending
    drive(2'b00, 0, 0, 1, CFI_CAUSE, 1, 0, 0, 0);
    tick("pend_pre_rst");
    drive(2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ex_valid", 64'(ifa.ex_o.valid), 64'h0);
    chk("arst.cnt",      64'(ifa.cnt_o), 64'h0);
    chk("arst.logv",     64'(ifa.log_valid_o), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, 64'($urandom_range(0, 15)),
            $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      tick($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
